// File: rtl/fc_bridge_pkg.sv
// fc_bridge_pkg: shared constants and buffer type for the FC-to-L2 data bridge
package fc_bridge_pkg;
  localparam logic [31:0] L2_ADDR_LO = 32'h1C00_0000;
  localparam logic [31:0] L2_ADDR_HI = 32'h1C08_0000;
  localparam logic [31:0] ERR_RDATA = 32'h0;
  localparam int ERR_CNT_W = 16;
  typedef struct packed {
    logic [31:0] addr;
    logic we;
    logic [3:0] be;
    logic [31:0] wdata;
  } l2_buf_t;
endpackage

// File: rtl/fc_l2_data_bridge.sv
// fc_l2_data_bridge: forwards in-window core data requests to the L2 TCDM port, answers out-of-window ones locally with an error
module fc_l2_data_bridge
  import fc_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = L2_ADDR_LO,
  parameter logic [31:0] ADDR_HI = L2_ADDR_HI,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic core_req_i,
  input  logic [31:0] core_addr_i,
  input  logic core_we_i,
  input  logic [3:0] core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic core_gnt_o,
  output logic core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic core_err_o,
  output logic l2_req_o,
  output logic [31:0] l2_add_o,
  output logic l2_wen_o,
  output logic [31:0] l2_wdata_o,
  output logic [3:0] l2_be_o,
  input  logic l2_gnt_i,
  input  logic l2_r_valid_i,
  input  logic [31:0] l2_r_rdata_i,
  input  logic l2_r_opc_i,
  output logic [ERR_CNT_W-1:0] err_count_o
);
  localparam logic [2:0] MAX_W = 3'(MAX_OUTSTANDING);
  logic buf_valid_q, buf_valid_d;
  l2_buf_t buf_q, buf_d;
  logic [2:0] outstanding_q, outstanding_d;
  logic err_pending_q, err_pending_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic in_range, l2_hs, rsp_ok, load;
  logic [2:0] inflight;
  always_comb begin
    in_range = core_addr_i >= ADDR_LO && core_addr_i < ADDR_HI;
    inflight = {2'b0, buf_valid_q} + outstanding_q;
    l2_hs = buf_valid_q & l2_gnt_i;
    rsp_ok = l2_r_valid_i & (outstanding_q != 3'd0);
    // buffer may be refilled in the same cycle it hands off to the bus
    core_gnt_o = ~rst_i & core_req_i & ~err_pending_q &
                 (in_range ? (inflight < MAX_W) & (~buf_valid_q | l2_gnt_i) : inflight == 3'd0);
    load = core_gnt_o & in_range;
    buf_valid_d = load | (buf_valid_q & ~l2_gnt_i);
    buf_d = load ? '{addr: core_addr_i, we: core_we_i, be: core_be_i, wdata: core_wdata_i} : buf_q;
    outstanding_d = outstanding_q + {2'b0, l2_hs} - {2'b0, rsp_ok};
    err_pending_d = core_gnt_o & ~in_range;
    err_count_d = err_pending_d && err_count_q != '1 ? err_count_q + 1'b1 : err_count_q;
    core_rvalid_o = ~rst_i & (err_pending_q | rsp_ok);
    core_err_o = ~rst_i & (err_pending_q | l2_r_opc_i);
    core_rdata_o = rst_i | err_pending_q ? ERR_RDATA : l2_r_rdata_i;
    l2_req_o = ~rst_i & buf_valid_q;
    l2_add_o = rst_i ? 32'h0 : buf_q.addr;
    l2_wen_o = rst_i | ~buf_q.we;
    l2_wdata_o = rst_i ? 32'h0 : buf_q.wdata;
    l2_be_o = rst_i ? 4'h0 : buf_q.be;
    err_count_o = err_count_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      buf_q <= '0;
      outstanding_q <= 3'd0;
      err_pending_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q <= buf_d;
      outstanding_q <= outstanding_d;
      err_pending_q <= err_pending_d;
      err_count_q <= err_count_d;
    end
  end
endmodule

// File: doc/fc_l2_data_bridge.md
FC_L2_DATA_BRIDGE -- requirements
Module: fc_l2_data_bridge

Interface
REQ-001 SHALL have parameter ADDR_LO, default 32'h1C00_0000, inclusive lower bound of the legal L2 window.
REQ-002 SHALL have parameter ADDR_HI, default 32'h1C08_0000, exclusive upper bound of the legal L2 window.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, range 1..4, the maximum number of core requests granted but not yet answered.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 core_req_i / core_addr_i / core_we_i / core_be_i / core_wdata_i  in  1/32/1/4/32  core data request (write enable active-high).
REQ-008 core_gnt_o  out  1  request accepted this cycle.
REQ-009 core_rvalid_o / core_rdata_o / core_err_o  out  1/32/1  response to the core.
REQ-010 l2_req_o / l2_add_o / l2_wen_o / l2_wdata_o / l2_be_o  out  1/32/1/32/4  TCDM request (wen active-low).
REQ-011 l2_gnt_i  in  1  bus grant.
REQ-012 l2_r_valid_i / l2_r_rdata_i / l2_r_opc_i  in  1/32/1  bus response.
REQ-013 err_count_o  out  16  saturating count of out-of-range accesses.

Function
REQ-014 SHALL define inflight as buf_valid plus outstanding, where outstanding counts bus-granted requests that have no response yet.
REQ-015 SHALL set core_gnt_o for an in-range request (ADDR_LO <= addr < ADDR_HI) when inflight < MAX_OUTSTANDING, err_pending = 0, and (buf_valid = 0 or l2_gnt_i = 1).
REQ-016 SHALL store a granted in-range request in a one-entry buffer, setting buf_valid the next cycle: one cycle of latency from core grant to l2_req_o.
REQ-017 SHALL drive l2_req_o = buf_valid and the l2 fields from the buffer, held stable until l2_gnt_i, with l2_wen_o = ~we.
REQ-018 SHALL clear buf_valid on l2_req_o & l2_gnt_i unless a new grant reloads it the same cycle (back-to-back throughput of 1 per cycle).
REQ-019 SHALL increment outstanding on l2 handshake and decrement it on l2_r_valid_i; when both occur in the same cycle the value is unchanged.
REQ-020 SHALL drive core_rvalid_o = l2_r_valid_i & (outstanding != 0), with core_rdata_o = l2_r_rdata_i and core_err_o = l2_r_opc_i (combinational pass-through).
REQ-021 SHALL silently drop an l2_r_valid_i that arrives while outstanding = 0.
REQ-022 SHALL grant an out-of-range request only when inflight = 0 and err_pending = 0, set err_pending, and not forward it to the bus.
REQ-023 While err_pending = 1, the next cycle SHALL drive core_rvalid_o = 1, core_err_o = 1, core_rdata_o = 32'h0, then clear err_pending; no grant is given in that cycle.
REQ-024 SHALL increment err_count_o on each out-of-range grant, saturating at 16'hFFFF.
REQ-025 SHALL keep core_gnt_o = 0 whenever core_req_i = 0.

Reset
REQ-026 On rst_i, SHALL clear buf_valid, outstanding, err_pending and err_count_o, and reset the buffer fields to 0.
REQ-027 During reset, outputs SHALL be: core_gnt_o = 0, core_rvalid_o = 0, core_err_o = 0, core_rdata_o = 0, l2_req_o = 0, l2_wen_o = 1, and all other l2 fields = 0.
REQ-028 A reset issued mid-transaction SHALL abandon the buffered request; late bus responses are dropped per REQ-021.

Structure
REQ-029 The ADDR_LO/ADDR_HI defaults, the error rdata constant 32'h0 and the counter width 16 SHALL live in the shared package fc_bridge_pkg.
REQ-030 SHALL be a single module with no sub-modules; the parent maps the l2_* ports onto an XBAR_TCDM_BUS master.

Verification
REQ-031 In-range read at 0x1C00_0100 with l2_gnt_i tied to 1 and a 1-cycle response 0xDEADBEEF -> l2_req_o is seen 1 cycle after core_gnt_o, and core_rvalid_o returns 0xDEADBEEF with core_err_o = 0.
REQ-032 Three back-to-back requests with MAX_OUTSTANDING = 2 and responses withheld -> two grants, the third stalls; the third is granted once the first response is returned, with no same-cycle credit.
REQ-033 l2_gnt_i held low for 3 cycles -> l2_add_o, l2_wdata_o and l2_be_o are stable for those cycles and core_gnt_o = 0.
REQ-034 Write to 0x0000_0000 while idle -> granted, zero l2_req_o activity, core_rvalid_o = 1 with core_err_o = 1 on the next cycle, err_count_o = 1.
REQ-035 rst_i pulsed with 2 requests outstanding, followed by 2 l2_r_valid_i pulses -> core_rvalid_o stays 0 and all counters read 0.
REQ-036 Forced 65,536 out-of-range accesses -> err_count_o saturates at 0xFFFF.
